// File: rtl/branch_mux_pkg.sv
// rtl/branch_mux_pkg.sv - shared constants for the branch offset mux
// Contents:
//   DEF_WIDTH     default branch offset width
//   DEF_CNT_WIDTH default taken-branch counter width
//   ZERO_OFFSET   all-zero offset driven when the branch is not taken
package branch_mux_pkg;
  localparam int DEF_WIDTH     = 16;
  localparam int DEF_CNT_WIDTH = 16;
  localparam logic [DEF_WIDTH-1:0] ZERO_OFFSET = '0;
endpackage

// File: rtl/branch_taken_counter.sv
// rtl/branch_taken_counter.sv - saturating count of taken branches
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset, clears count
//   inc   in   increment request for this cycle
//   count out  registered count, sticks at all-ones
module branch_taken_counter
  import branch_mux_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_at_max;

  assign w_at_max = (r_count == {CNT_WIDTH{1'b1}});

  // Reset wins over a same-edge increment; saturation blocks wrap to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && !w_at_max) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/branch_mux.sv
// rtl/branch_mux.sv - branch offset select with flags and taken-branch history
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset (registered state only)
//   Branch_Inst in   two's complement branch offset from decode
//   Branch_Sel  in   1 = branch taken, pass offset; 0 = force zero
//   B_Mux_Out   out  selected offset to the PC adder (combinational)
//   B_Neg       out  sign bit of B_Mux_Out (combinational)
//   B_Zero      out  B_Mux_Out is zero (combinational)
//   Last_Offset out  most recent taken offset (registered)
//   Taken_Cnt   out  saturating count of taken cycles (registered)
module branch_mux
  import branch_mux_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     Branch_Inst,
  input  logic                 Branch_Sel,
  output logic [WIDTH-1:0]     B_Mux_Out,
  output logic                 B_Neg,
  output logic                 B_Zero,
  output logic [WIDTH-1:0]     Last_Offset,
  output logic [CNT_WIDTH-1:0] Taken_Cnt
);

  logic [WIDTH-1:0] w_zero_off;
  logic [WIDTH-1:0] w_mux;
  logic [WIDTH-1:0] r_last_offset;

  // Zero-extends or truncates the package constant to this instance's width.
  assign w_zero_off = WIDTH'(ZERO_OFFSET);

  // Pure combinational path: no dependence on clk or rst.
  assign w_mux     = Branch_Sel ? Branch_Inst : w_zero_off;
  assign B_Mux_Out = w_mux;
  assign B_Neg     = w_mux[WIDTH-1];
  assign B_Zero    = (w_mux == w_zero_off);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_offset <= '0;
    end else if (Branch_Sel) begin
      r_last_offset <= Branch_Inst;
    end
  end

  assign Last_Offset = r_last_offset;

  branch_taken_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_taken_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (Branch_Sel),
    .count(Taken_Cnt)
  );

endmodule

// File: tb/tb_branch_mux.sv
// tb/tb_branch_mux.sv - scoreboard bench for branch_mux
module tb_branch_mux;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic [15:0] Branch_Inst;
  logic        Branch_Sel;
  logic [15:0] B_Mux_Out;
  logic        B_Neg;
  logic        B_Zero;
  logic [15:0] Last_Offset;
  logic [15:0] Taken_Cnt;

  typedef struct {
    string       name;
    logic [15:0] mux;
    logic        neg;
    logic        zero;
    logic        regs;
    logic [15:0] last;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  logic smp;
  int   checks;
  int   errors;

  branch_mux #(
    .WIDTH(16),
    .CNT_WIDTH(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Branch_Inst(Branch_Inst),
    .Branch_Sel (Branch_Sel),
    .B_Mux_Out  (B_Mux_Out),
    .B_Neg      (B_Neg),
    .B_Zero     (B_Zero),
    .Last_Offset(Last_Offset),
    .Taken_Cnt  (Taken_Cnt)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  // Monitor: drains the scoreboard each time the stimulus strobes a sample.
  always @(smp) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic bad;
      e = exp_q.pop_front();
      checks = checks + 1;
      bad = (B_Mux_Out !== e.mux) || (B_Neg !== e.neg) || (B_Zero !== e.zero);
      if (e.regs && ((Last_Offset !== e.last) || (Taken_Cnt !== e.cnt))) bad = 1'b1;
      if (bad) begin
        errors = errors + 1;
        $display("FAIL %s: got mux=%h neg=%b zero=%b last=%h cnt=%h, want mux=%h neg=%b zero=%b last=%h cnt=%h (regs checked=%b)",
                 e.name, B_Mux_Out, B_Neg, B_Zero, Last_Offset, Taken_Cnt,
                 e.mux, e.neg, e.zero, e.last, e.cnt, e.regs);
      end
    end
  end

  task automatic expect_now(input string nm, input logic [15:0] mux, input logic neg,
                            input logic zero, input logic regs, input logic [15:0] last,
                            input logic [15:0] cnt);
    exp_t e;
    #1;
    e.name = nm; e.mux = mux; e.neg = neg; e.zero = zero;
    e.regs = regs; e.last = last; e.cnt = cnt;
    exp_q.push_back(e);
    smp = ~smp;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; smp = 1'b0;
    clk_en = 1'b0; rst = 1'b0;

    // Combinational path with no clock running.
    Branch_Inst = 16'h1234; Branch_Sel = 1'b0;
    expect_now("noclk_sel0", 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
    Branch_Sel = 1'b1;
    expect_now("noclk_sel1", 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    Branch_Inst = 16'hFFFF;
    expect_now("noclk_ffff", 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    Branch_Inst = 16'h0000;
    expect_now("noclk_zero_taken", 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
    Branch_Inst = 16'h8000; Branch_Sel = 1'b0;
    rst = 1'b1;
    expect_now("rst_comb_sel0", 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);

    // Reset together with a taken branch: reset wins, mux still passes.
    clk_en = 1'b1;
    Branch_Inst = 16'hABCD; Branch_Sel = 1'b1;
    tick();
    expect_now("rst_vs_take", 16'hABCD, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
    Branch_Sel = 1'b0;
    tick();
    expect_now("reset_state", 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);

    rst = 1'b0;
    Branch_Inst = 16'hFFFF; Branch_Sel = 1'b1;
    expect_now("pre_edge_hold", 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
    tick();
    expect_now("ffff_captured", 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0001);

    // Reset pulse, then 3 taken and 2 not-taken edges.
    rst = 1'b1; Branch_Sel = 1'b0;
    tick();
    expect_now("rst_pulse", 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
    rst = 1'b0;
    Branch_Inst = 16'h0010; Branch_Sel = 1'b1;
    tick();
    expect_now("take1", 16'h0010, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0001);
    Branch_Inst = 16'h0020;
    tick();
    Branch_Inst = 16'h8030;
    tick();
    expect_now("take3", 16'h8030, 1'b1, 1'b0, 1'b1, 16'h8030, 16'h0003);
    Branch_Inst = 16'h5555; Branch_Sel = 1'b0;
    tick();
    tick();
    expect_now("hold_after_2", 16'h0000, 1'b0, 1'b1, 1'b1, 16'h8030, 16'h0003);

    // Mid-operation reset with a simultaneous taken branch.
    rst = 1'b1; Branch_Inst = 16'h7777; Branch_Sel = 1'b1;
    tick();
    expect_now("mid_rst_take", 16'h7777, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);

    // Drive the counter up to 16'hFFFE, then past the top.
    rst = 1'b0; Branch_Inst = 16'h0001; Branch_Sel = 1'b1;
    repeat (65534) tick();
    expect_now("cnt_fffe", 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0001, 16'hFFFE);
    Branch_Inst = 16'h0002;
    tick();
    expect_now("cnt_ffff", 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0002, 16'hFFFF);
    tick();
    tick();
    expect_now("cnt_saturate", 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0002, 16'hFFFF);
    Branch_Sel = 1'b0;
    tick();
    expect_now("sat_hold", 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0002, 16'hFFFF);

    // Counting resumes from zero after reset.
    rst = 1'b1;
    tick();
    rst = 1'b0; Branch_Inst = 16'h4321; Branch_Sel = 1'b1;
    tick();
    expect_now("resume_after_rst", 16'h4321, 1'b0, 1'b0, 1'b1, 16'h4321, 16'h0001);

    begin
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 100) begin
        #1;
        waited++;
      end
      if (exp_q.size() > 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
